drv_led_10w_dec: RTL and testbench
==================================

# drv_led_10w_dec

Output-side counterpart of the 10-way switch driver with encoder: accepts a 4-bit index 0..9 with a load strobe and drives a row of 10 LEDs one-hot. The index is latched, decoded, and gated by a prescaled PWM brightness generator and an optional blink generator. All pad outputs are registered. The block sits between a control FSM or register bank and the LED pads.

## Interface
- p_scale, 5: prescaler width; one tick every 2^p_scale clocks; legal range 1..16.
- p_blink, 6: blink counter width in ticks; blink half-period is 2^(p_blink-1) ticks; legal range 2..16.
- p_mode, "pullup": "pullup" means LED lit = 0 and dark = 1; "pulldown" means LED lit = 1 and dark = 0.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_val  in  4  LED index to display, 0..9.
- i_load  in  1  single-cycle strobe that latches i_val.
- i_blink  in  1  level; 1 enables blinking of the lit LED.
- i_bright  in  3  PWM duty setting, sampled live.
- o_drv_led  out  10  pad drive, polarity per p_mode.
- o_unknown  out  1  last loaded index was outside 0..9.
- o_change  out  1  one-cycle pulse when a load changes the displayed index.

## Operation
- **Reset** (i_rst=1, asynchronous):
  - r_val=0, r_en=0, o_unknown=0, o_change=0.
  - Prescaler, PWM and blink counters are 0.
  - o_drv_led is all dark: 10'h3FF for pullup, 10'h000 for pulldown.
- **Load with i_val in 0..9:**
  - r_val←i_val, r_en←1, o_unknown←0.
  - o_change←1 for one cycle if r_en was 0 or r_val≠i_val.
- **Load with i_val in 10..15:**
  - r_en←0 (display blank), o_unknown←1, r_val unchanged, o_change←0.
- Any load clears the blink counter, so a new value starts in the lit phase.
- **Prescaler:** free-running p_scale-bit counter; tick=1 when the count is all ones.
- **PWM:** 3-bit counter, +1 on each tick, wraps 7→0. pwm_on = (pwm_cnt ≤ i_bright). i_bright=7 gives full on; i_bright=0 gives 1/8 duty.
- **Blink:** p_blink-bit counter, +1 on each tick, wraps. blink_on = ~i_blink | ~blink_cnt[MSB].
- **Lit vector:** lit[i] = r_en & (r_val==i) & pwm_on & blink_on.
- **Pad output:** registered as o_drv_led ← (p_mode=="pullup") ? ~lit : lit. Unsupported p_mode strings behave as "pulldown".
- **Simultaneous events:** a load arriving on a tick cycle clears the blink counter, and the clear takes priority over the increment. The PWM counter is not affected by a load.
- At most one LED is ever lit.

## Timing
- i_load sampled high at edge k: r_val, r_en, o_unknown and o_change update at edge k.
- o_drv_led reflects the new value at edge k+1, i.e. 2 cycles after the strobe is presented.
- o_change is high for exactly the cycle after edge k.
- Tick period is 2^p_scale clocks.
- PWM frame is 8 ticks.
- Blink period is 2^p_blink ticks, with 50% duty.
- i_bright and i_blink take effect at the next edge through the output register, i.e. 1-cycle latency.
- Reset deassertion: the first increment of any counter occurs at the first rising edge with i_rst=0.

## Configuration
- Macro: DRV_LED_PWM_EN.
- **Defined:** PWM counter and brightness compare are built as described above.
- **Undefined:**
  - pwm_on is constant 1 and i_bright is ignored (unconnected).
  - The PWM counter is not instantiated.
  - Blink still advances on ticks.

## Test plan
- **Reset:** assert i_rst mid-operation with p_mode="pullup" → o_drv_led=10'h3FF immediately (asynchronously), o_unknown=0, o_change=0, all counters 0.
- **Basic decode:** i_bright=7, i_blink=0, load i_val=3 → o_change pulses 1 cycle; 2 cycles later o_drv_led=10'b1111110111 (pullup) or 10'b0000001000 (pulldown); reloading 3 gives no o_change pulse.
- **Invalid index:** load i_val=12 → o_unknown=1, display all dark next cycle. Then load i_val=9 → o_unknown=0, o_change=1, bit 9 lit.
- **PWM duty** (p_scale=2, i_bright=1, value 0 loaded): over 32 clocks, bit 0 is lit for exactly 8 clocks (2 ticks of every 8-tick frame). With DRV_LED_PWM_EN undefined: lit for all 32 clocks.
- **Blink** (p_scale=1, p_blink=3, i_blink=1): LED lit for 8 clocks, dark for 8 clocks, repeating. A load mid-dark-phase restarts the lit phase (visible after 1 output-register cycle).
- **Load on a tick edge:** blink counter reads 0 after the edge, not 1; the PWM counter advances normally.

Source files
------------

// File: rtl/drv_led_10w_dec.sv
// drv_led_10w_dec: latches a 0..9 index and drives 10 LEDs one-hot,
// gated by prescaled PWM brightness and an optional blink generator.
// Ports: i_clk, i_rst (async, high), i_val[3:0], i_load, i_blink,
//   i_bright[2:0] -> o_drv_led[9:0], o_unknown, o_change.
// Params: p_scale (tick = 2^p_scale clks), p_blink, p_mode.
// Macro DRV_LED_PWM_EN builds the PWM stage; otherwise pwm is always on.
module drv_led_10w_dec #(
  parameter int unsigned p_scale = 5,
  parameter int unsigned p_blink = 6,
  parameter string       p_mode  = "pullup"
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_val,
  input  logic       i_load,
  input  logic       i_blink,
  input  logic [2:0] i_bright,
  output logic [9:0] o_drv_led,
  output logic       o_unknown,
  output logic       o_change
);

  localparam bit PullUp = (p_mode == "pullup");
  localparam logic [9:0] Dark = PullUp ? 10'h3FF : 10'h000;

  logic [p_scale-1:0] pre_q, pre_d;
  logic [p_blink-1:0] blk_q, blk_d;
  logic [3:0]         val_q, val_d;
  logic               en_q, en_d;
  logic               unk_q, unk_d;
  logic               chg_q, chg_d;
  logic [9:0]         led_q, led_d;
  logic [9:0]         lit;
  logic               tick;
  logic               valid;
  logic               pwm_on;
  logic               blink_on;

  assign tick  = &pre_q;
  assign pre_d = pre_q + 1'b1;
  assign valid = (i_val <= 4'd9);

`ifdef DRV_LED_PWM_EN
  logic [2:0] pwm_q, pwm_d;

  // Loads never touch the PWM frame.
  assign pwm_d  = tick ? pwm_q + 3'd1 : pwm_q;
  assign pwm_on = (pwm_q <= i_bright);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pwm_q <= '0;
    else       pwm_q <= pwm_d;
  end
`else
  logic unused_bright;

  assign unused_bright = ^i_bright;
  assign pwm_on        = 1'b1;
`endif

  assign blink_on = ~i_blink | ~blk_q[p_blink-1];

  always_comb begin
    val_d = val_q;
    en_d  = en_q;
    unk_d = unk_q;
    chg_d = 1'b0;
    blk_d = tick ? blk_q + 1'b1 : blk_q;
    if (i_load) begin
      // Clear wins over a same-cycle tick.
      blk_d = '0;
      if (valid) begin
        val_d = i_val;
        en_d  = 1'b1;
        unk_d = 1'b0;
        chg_d = ~en_q | (val_q != i_val);
      end else begin
        en_d  = 1'b0;
        unk_d = 1'b1;
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < 10; i++) begin
      lit[i] = en_q & (val_q == 4'(i)) & pwm_on & blink_on;
    end
    led_d = PullUp ? ~lit : lit;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pre_q <= '0;
      blk_q <= '0;
      val_q <= '0;
      en_q  <= 1'b0;
      unk_q <= 1'b0;
      chg_q <= 1'b0;
      led_q <= Dark;
    end else begin
      pre_q <= pre_d;
      blk_q <= blk_d;
      val_q <= val_d;
      en_q  <= en_d;
      unk_q <= unk_d;
      chg_q <= chg_d;
      led_q <= led_d;
    end
  end

  assign o_drv_led = led_q;
  assign o_unknown = unk_q;
  assign o_change  = chg_q;

endmodule

// File: tb/tb_drv_led_10w_dec.sv
// Bench for drv_led_10w_dec: two instances (pullup and pulldown)
// checked against a tick-count arithmetic model.
module tb_drv_led_10w_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] val;
  logic       load;
  logic       blink;
  logic [2:0] bright;
  logic [9:0] led_a, led_b;
  logic       unk_a, unk_b, chg_a, chg_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  drv_led_10w_dec #(
    .p_scale(2), .p_blink(4), .p_mode("pullup")
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_val(val), .i_load(load),
    .i_blink(blink), .i_bright(bright),
    .o_drv_led(led_a), .o_unknown(unk_a), .o_change(chg_a)
  );

  drv_led_10w_dec #(
    .p_scale(1), .p_blink(3), .p_mode("pulldown")
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_val(val), .i_load(load),
    .i_blink(blink), .i_bright(bright),
    .o_drv_led(led_b), .o_unknown(unk_b), .o_change(chg_b)
  );

  // Model: counters derived from clocks since reset and ticks since load.
  int         S[2]  = '{2, 1};
  int         PB[2] = '{4, 3};
  bit         PU[2] = '{1'b1, 1'b0};
  int         m_cyc[2];
  int         m_tl[2];
  int         m_val;
  bit         m_en, m_unk, m_chg;
  logic [9:0] m_led[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cyc[k] = 0;
      m_tl[k]  = 0;
      m_led[k] = PU[k] ? 10'h3FF : 10'h000;
    end
    m_val = 0;
    m_en  = 1'b0;
    m_unk = 1'b0;
    m_chg = 1'b0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int t;
      int bc;
      bit pon;
      bit bon;
      logic [9:0] lt;
      t  = m_cyc[k] >> S[k];
      bc = (t - m_tl[k]) % (1 << PB[k]);
`ifdef DRV_LED_PWM_EN
      pon = ((t % 8) <= int'(bright));
`else
      pon = 1'b1;
`endif
      bon = !blink || (bc < (1 << (PB[k] - 1)));
      lt  = (m_en && pon && bon) ? (10'd1 << m_val) : 10'd0;
      m_led[k] = PU[k] ? ~lt : lt;
    end
    m_chg = 1'b0;
    if (load) begin
      if (val <= 4'd9) begin
        m_chg = !m_en || (m_val != int'(val));
        m_val = int'(val);
        m_en  = 1'b1;
        m_unk = 1'b0;
      end else begin
        m_en  = 1'b0;
        m_unk = 1'b1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      m_cyc[k]++;
      if (load) m_tl[k] = m_cyc[k] >> S[k];
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (led_a !== 10'h3FF) begin
      errors++;
      $display("FAIL reset_led_a got %h want 3ff", led_a);
    end
    checks++;
    if (led_b !== 10'h000) begin
      errors++;
      $display("FAIL reset_led_b got %h want 000", led_b);
    end
    checks++;
    if (unk_a !== 1'b0 || chg_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got unk=%b chg=%b want 0 0", unk_a, chg_a);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_decode();
    bright = 3'd7;
    blink  = 1'b0;
    val    = 4'd3;
    load   = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (chg_a !== 1'b1 || chg_b !== 1'b1) begin
      errors++;
      $display("FAIL decode_change got %b%b want 11", chg_a, chg_b);
    end
    step();
    checks++;
    if (chg_a !== 1'b0) begin
      errors++;
      $display("FAIL decode_change_width got %b want 0", chg_a);
    end
    checks++;
    if (led_a !== 10'b1111110111) begin
      errors++;
      $display("FAIL decode_led_a got %b want 1111110111", led_a);
    end
    checks++;
    if (led_b !== 10'b0000001000) begin
      errors++;
      $display("FAIL decode_led_b got %b want 0000001000", led_b);
    end
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (chg_a !== 1'b0) begin
      errors++;
      $display("FAIL reload_change got %b want 0", chg_a);
    end
  endtask

  task automatic test_invalid();
    val  = 4'd12;
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (unk_a !== 1'b1 || unk_b !== 1'b1 || chg_a !== 1'b0) begin
      errors++;
      $display("FAIL invalid_flags got unk=%b chg=%b want 1 0", unk_a, chg_a);
    end
    step();
    checks++;
    if (led_a !== 10'h3FF || led_b !== 10'h000) begin
      errors++;
      $display("FAIL invalid_dark got %h %h want 3ff 000", led_a, led_b);
    end
    val  = 4'd9;
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (unk_a !== 1'b0 || chg_a !== 1'b1) begin
      errors++;
      $display("FAIL valid_after_invalid got unk=%b chg=%b want 0 1", unk_a, chg_a);
    end
    step();
    checks++;
    if (led_a !== 10'h1FF || led_b !== 10'h200) begin
      errors++;
      $display("FAIL led9 got %h %h want 1ff 200", led_a, led_b);
    end
  endtask

  task automatic test_pwm_duty();
    int na;
    int nb;
    int want;
    na     = 0;
    nb     = 0;
    bright = 3'd1;
    blink  = 1'b0;
    val    = 4'd0;
    load   = 1'b1;
    step();
    load = 1'b0;
    step();
    for (int i = 0; i < 32; i++) begin
      step();
      if (led_a[0] === 1'b0) na++;
      if (led_b[0] === 1'b1) nb++;
    end
`ifdef DRV_LED_PWM_EN
    want = 8;
`else
    want = 32;
`endif
    checks++;
    if (na != want) begin
      errors++;
      $display("FAIL pwm_duty_a got %0d want %0d", na, want);
    end
    checks++;
    if (nb != want) begin
      errors++;
      $display("FAIL pwm_duty_b got %0d want %0d", nb, want);
    end
  endtask

  task automatic test_blink();
    int n;
    int guard;
    n      = 0;
    bright = 3'd7;
    blink  = 1'b1;
    val    = 4'd5;
    load   = 1'b1;
    step();
    load = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      if (led_b[5] === 1'b1) n++;
      step();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL blink_duty got %0d want 8", n);
    end
    guard = 0;
    while (led_b[5] !== 1'b0 && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL blink_dark_timeout got lit want dark");
    end
    step();
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    checks++;
    if (led_b !== 10'h020 || led_b !== m_led[1]) begin
      errors++;
      $display("FAIL blink_restart got %h want 020", led_b);
    end
  endtask

  task automatic test_load_on_tick();
    int n;
    n      = 0;
    bright = 3'd7;
    blink  = 1'b1;
    val    = 4'd7;
    if ((m_cyc[1] % 2) != 1) step();
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    while (led_b[7] === 1'b1 && n < 20) begin
      n++;
      step();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL load_on_tick lit_run got %0d want 8", n);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 3) == 0);
      val  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bright = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) blink = ~blink;
      step();
      checks++;
      if (led_a !== m_led[0]) begin
        errors++;
        $display("FAIL rand_led_a cyc %0d got %h want %h", i, led_a, m_led[0]);
      end
      checks++;
      if (led_b !== m_led[1]) begin
        errors++;
        $display("FAIL rand_led_b cyc %0d got %h want %h", i, led_b, m_led[1]);
      end
      checks++;
      if (unk_b !== m_unk || chg_b !== m_chg) begin
        errors++;
        $display("FAIL rand_flags cyc %0d got %b%b want %b%b",
                 i, unk_b, chg_b, m_unk, m_chg);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    val    = '0;
    load   = 1'b0;
    blink  = 1'b0;
    bright = '0;
    model_reset();
    #12;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    test_reset();
    test_basic_decode();
    test_invalid();
    test_pwm_duty();
    test_blink();
    test_load_on_tick();
    test_random();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
